difftest_commit_queue: RTL

- Producer end of the difftest path. Captures retired-instruction records from the writeback stage and buffers them in a small FIFO.
- Drains records one at a time to the C-side checker over a valid/ready handshake.
- Maintains a shadow architectural GPR file and a CSR snapshot, updated only when a record drains. The register-exposure module therefore always sees state consistent with the last record handed to the checker.
- Sits between the writeback stage and the DPI register-exposure module.

---
 rtl/difftest_pkg.sv | 34 +++
 rtl/difftest_sync_fifo.sv | 60 ++++++
 rtl/difftest_commit_queue.sv | 112 +++++++++++
 3 files changed

// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest commit path.
// Record layout, CSR slot indices and shadow-state reset values.
package difftest_pkg;

  localparam int NUM_CSR    = 5;
  localparam int CSR_CRMD   = 0;
  localparam int CSR_PRMD   = 1;
  localparam int CSR_ESTAT  = 2;
  localparam int CSR_ERA    = 3;
  localparam int CSR_EENTRY = 4;

  localparam logic [31:0] CRMD_RESET = 32'h8;

  typedef logic [NUM_CSR-1:0][31:0] csr_vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        excp;
    logic [5:0]  ecode;
    csr_vec_t    csr;
  } commit_rec_t;

  function automatic csr_vec_t csr_reset();
    csr_vec_t v;
    v = '0;
    v[CSR_CRMD] = CRMD_RESET;
    return v;
  endfunction

endpackage

// File: rtl/difftest_sync_fifo.sv
// Generic registered FIFO with occupancy counter.
// Head is read combinationally; no write-to-read bypass.
module difftest_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/difftest_commit_queue.sv
// Buffers retired-instruction records for the checker and keeps
// shadow GPR/CSR state that only advances as records drain.
module difftest_commit_queue
  import difftest_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmt_valid,
  output logic             cmt_ready,
  input  logic [31:0]      cmt_pc,
  input  logic [31:0]      cmt_inst,
  input  logic             cmt_rf_we,
  input  logic [4:0]       cmt_rf_waddr,
  input  logic [31:0]      cmt_rf_wdata,
  input  logic             cmt_excp,
  input  logic [5:0]       cmt_ecode,
  input  logic [31:0]      cmt_crmd,
  input  logic [31:0]      cmt_prmd,
  input  logic [31:0]      cmt_estat,
  input  logic [31:0]      cmt_era,
  input  logic [31:0]      cmt_eentry,
  output logic             dt_valid,
  input  logic             dt_ready,
  output logic [31:0]      dt_pc,
  output logic [31:0]      dt_inst,
  output logic             dt_excp,
  output logic [5:0]       dt_ecode,
  output logic [1023:0]    gpr_flat,
  output logic [159:0]     csr_flat,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             overflow
);

  commit_rec_t w_in;
  commit_rec_t w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;

  logic [31:0][31:0] r_gpr;
  csr_vec_t          r_csr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  always_comb begin
    w_in       = '0;
    w_in.pc    = cmt_pc;
    w_in.inst  = cmt_inst;
    // A faulting instruction never commits its GPR write.
    w_in.rf_we = cmt_rf_we & ~cmt_excp;
    w_in.waddr = cmt_rf_waddr;
    w_in.wdata = cmt_rf_wdata;
    w_in.excp  = cmt_excp;
    w_in.ecode = cmt_ecode;
    w_in.csr[CSR_CRMD]   = cmt_crmd;
    w_in.csr[CSR_PRMD]   = cmt_prmd;
    w_in.csr[CSR_ESTAT]  = cmt_estat;
    w_in.csr[CSR_ERA]    = cmt_era;
    w_in.csr[CSR_EENTRY] = cmt_eentry;
  end

  difftest_sync_fifo #(
    .WIDTH ($bits(commit_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (cmt_valid),
    .i_wdata (w_in),
    .i_pop   (dt_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop     = ~w_empty & dt_ready;
  assign cmt_ready = ~w_full;
  assign dt_valid  = ~w_empty;
  assign dt_pc     = w_head.pc;
  assign dt_inst   = w_head.inst;
  assign dt_excp   = w_head.excp;
  assign dt_ecode  = w_head.ecode;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_gpr <= '0;
      r_csr <= csr_reset();
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (cmt_valid && w_full) begin
        r_ovf <= 1'b1;
      end
      if (w_pop) begin
        if (w_head.rf_we && (w_head.waddr != 5'd0)) begin
          r_gpr[w_head.waddr] <= w_head.wdata;
        end
        r_csr <= w_head.csr;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign gpr_flat    = r_gpr;
  assign csr_flat    = r_csr;
  assign retired_cnt = r_cnt;
  assign overflow    = r_ovf;

endmodule
